rob_ctrl: RTL and testbench

//  Sequencer for the reorder buffer storage: owns head/tail pointers and per-entry VALID/COMPLETE state.

---
 rtl/rob_pkg.sv | 9 +
 rtl/rob_ptr.sv | 32 +++
 rtl/rob_ctrl.sv | 118 +++++++++++
 tb/tb_rob_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared constants and types for the reorder-buffer controller slice.
package rob_pkg;
   localparam int ROB_DEPTH      = 64;
   localparam int ROB_IDX_W      = 6;
   localparam int RETIRE_WIDTH   = 2;
   localparam int NUM_CMPL_PORTS = 3;

   typedef logic [ROB_IDX_W-1:0] rob_idx_t;
endpackage

// File: rtl/rob_ptr.sv
// Modulo-DEPTH ring pointer. It advances by 0..2 per cycle, and clr returns it to zero.
module rob_ptr
   import rob_pkg::*;
#(
   parameter int IDX_W = ROB_IDX_W
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic [1:0]       inc,
   output logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] ptr_plus1
);

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;

   // DEPTH is a power of two, so the natural IDX_W-bit overflow is the modulo wrap.
   always_comb begin
      ptr_d = ptr_q + IDX_W'(inc);
      if (clr) ptr_d = '0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

   assign ptr       = ptr_q;
   assign ptr_plus1 = ptr_q + IDX_W'(1);

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer sequencer: head/tail pointers, per-entry VALID/COMPLETE state,
// in-order dual retirement and the dispatch stall.
module rob_ctrl
   import rob_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int IDX_W = ROB_IDX_W
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             flush,
   input  logic             alloc_req,
   output logic             alloc_ready,
   output logic [IDX_W-1:0] alloc_idx,
   output logic             stall,
   input  logic             cmpl_v_0,
   input  logic [IDX_W-1:0] cmpl_idx_0,
   input  logic             cmpl_v_1,
   input  logic [IDX_W-1:0] cmpl_idx_1,
   input  logic             cmpl_v_2,
   input  logic [IDX_W-1:0] cmpl_idx_2,
   output logic             retire_v_0,
   output logic [IDX_W-1:0] retire_idx_0,
   output logic             retire_v_1,
   output logic [IDX_W-1:0] retire_idx_1,
   output logic [IDX_W:0]   count,
   output logic             empty
);

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] cmpl_q,  cmpl_d;
   logic [IDX_W:0]   count_q, count_d;

   logic [IDX_W-1:0] head, head_plus1;
   logic [IDX_W-1:0] tail, tail_plus1_unused;
   logic             alloc_fire;
   logic [1:0]       retire_n;

   logic [NUM_CMPL_PORTS-1:0] cmpl_v;
   logic [IDX_W-1:0]          cmpl_idx [NUM_CMPL_PORTS];

   assign cmpl_v      = {cmpl_v_2, cmpl_v_1, cmpl_v_0};
   assign cmpl_idx[0] = cmpl_idx_0;
   assign cmpl_idx[1] = cmpl_idx_1;
   assign cmpl_idx[2] = cmpl_idx_2;

   rob_ptr #(.IDX_W(IDX_W)) u_head (
      .clk       (clk),
      .rstn      (rstn),
      .clr       (flush),
      .inc       (retire_n),
      .ptr       (head),
      .ptr_plus1 (head_plus1)
   );

   rob_ptr #(.IDX_W(IDX_W)) u_tail (
      .clk       (clk),
      .rstn      (rstn),
      .clr       (flush),
      .inc       ({1'b0, alloc_fire}),
      .ptr       (tail),
      .ptr_plus1 (tail_plus1_unused)
   );

   // Readiness looks only at the registered count, so a slot freed by a retire
   // is not offered to dispatch until the following cycle.
   assign alloc_ready = (count_q < (IDX_W+1)'(DEPTH));
   assign alloc_fire  = alloc_req & alloc_ready;
   assign retire_v_0  = valid_q[head] & cmpl_q[head];
   assign retire_v_1  = retire_v_0 & valid_q[head_plus1] & cmpl_q[head_plus1];
   assign retire_n    = {1'b0, retire_v_0} + {1'b0, retire_v_1};

   always_comb begin
      valid_d = valid_q;
      cmpl_d  = cmpl_q;
      for (int k = 0; k < NUM_CMPL_PORTS; k++) begin
         if (cmpl_v[k] && valid_q[cmpl_idx[k]]) cmpl_d[cmpl_idx[k]] = 1'b1;
      end
      if (retire_v_0) begin
         valid_d[head] = 1'b0;
         cmpl_d[head]  = 1'b0;
      end
      if (retire_v_1) begin
         valid_d[head_plus1] = 1'b0;
         cmpl_d[head_plus1]  = 1'b0;
      end
      if (alloc_fire) begin
         valid_d[tail] = 1'b1;
         cmpl_d[tail]  = 1'b0;
      end
      count_d = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(retire_n);
      if (flush) begin
         valid_d = '0;
         cmpl_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q <= '0;
         cmpl_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         cmpl_q  <= cmpl_d;
         count_q <= count_d;
      end
   end

   assign alloc_idx    = tail;
   assign stall        = ~alloc_ready;
   assign retire_idx_0 = head;
   assign retire_idx_1 = head_plus1;
   assign count        = count_q;
   assign empty        = (count_q == '0);

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl: allocation, completion, dual retire, full, wrap, flush and reset.
module tb_rob_ctrl;
   import rob_pkg::*;

   logic     clk = 1'b0;
   logic     rstn = 1'b0;
   logic     flush = 1'b0;
   logic     alloc_req = 1'b0;
   logic     alloc_ready, stall, empty;
   rob_idx_t alloc_idx;
   logic     cmpl_v_0 = 1'b0, cmpl_v_1 = 1'b0, cmpl_v_2 = 1'b0;
   rob_idx_t cmpl_idx_0 = '0, cmpl_idx_1 = '0, cmpl_idx_2 = '0;
   logic     retire_v_0, retire_v_1;
   rob_idx_t retire_idx_0, retire_idx_1;
   logic [ROB_IDX_W:0] count;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   rob_ctrl dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx), .stall(stall),
      .cmpl_v_0(cmpl_v_0), .cmpl_idx_0(cmpl_idx_0),
      .cmpl_v_1(cmpl_v_1), .cmpl_idx_1(cmpl_idx_1),
      .cmpl_v_2(cmpl_v_2), .cmpl_idx_2(cmpl_idx_2),
      .retire_v_0(retire_v_0), .retire_idx_0(retire_idx_0),
      .retire_v_1(retire_v_1), .retire_idx_1(retire_idx_1),
      .count(count), .empty(empty)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_cmpl();
      cmpl_v_0 = 1'b0; cmpl_v_1 = 1'b0; cmpl_v_2 = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_total++; if (alloc_ready !== 1'b1) $display("FAIL rst_alloc_ready got %0d exp 1", alloc_ready); else n_pass++;
      n_total++; if (stall !== 1'b0) $display("FAIL rst_stall got %0d exp 0", stall); else n_pass++;
      n_total++; if (alloc_idx !== 6'd0) $display("FAIL rst_alloc_idx got %0d exp 0", alloc_idx); else n_pass++;
      n_total++; if (empty !== 1'b1 || count !== 7'd0) $display("FAIL rst_count got %0d/%0d exp 0/1", count, empty); else n_pass++;
      n_total++; if (retire_v_0 !== 1'b0 || retire_v_1 !== 1'b0) $display("FAIL rst_retire_v got %0d%0d exp 00", retire_v_0, retire_v_1); else n_pass++;
      n_total++; if (retire_idx_0 !== 6'd0 || retire_idx_1 !== 6'd1) $display("FAIL rst_retire_idx got %0d,%0d exp 0,1", retire_idx_0, retire_idx_1); else n_pass++;
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_alloc_basic();
      for (int i = 0; i < 3; i++) begin
         alloc_req = 1'b1;
         n_total++; if (alloc_idx !== 6'(i)) $display("FAIL alloc_idx got %0d exp %0d", alloc_idx, i); else n_pass++;
         tick();
      end
      alloc_req = 1'b0;
      n_total++; if (count !== 7'd3) $display("FAIL alloc_count got %0d exp 3", count); else n_pass++;
      cmpl_v_0 = 1'b1; cmpl_idx_0 = 6'd1;
      tick();
      clr_cmpl();
      n_total++; if (retire_v_0 !== 1'b0) $display("FAIL head_incomplete_retire got %0d exp 0", retire_v_0); else n_pass++;
      n_total++; if (count !== 7'd3) $display("FAIL head_incomplete_count got %0d exp 3", count); else n_pass++;
   endtask

   task automatic test_complete_retire();
      cmpl_v_0 = 1'b1; cmpl_idx_0 = 6'd0;
      cmpl_v_2 = 1'b1; cmpl_idx_2 = 6'd2;
      n_total++; if (retire_v_0 !== 1'b0) $display("FAIL cmpl_latency got %0d exp 0", retire_v_0); else n_pass++;
      tick();
      clr_cmpl();
      n_total++; if (retire_v_0 !== 1'b1 || retire_v_1 !== 1'b1) $display("FAIL dual_retire_v got %0d%0d exp 11", retire_v_0, retire_v_1); else n_pass++;
      n_total++; if (retire_idx_0 !== 6'd0 || retire_idx_1 !== 6'd1) $display("FAIL dual_retire_idx got %0d,%0d exp 0,1", retire_idx_0, retire_idx_1); else n_pass++;
      tick();
      n_total++; if (retire_v_0 !== 1'b1 || retire_v_1 !== 1'b0 || retire_idx_0 !== 6'd2) $display("FAIL single_retire got v%0d%0d idx %0d exp v10 idx 2", retire_v_0, retire_v_1, retire_idx_0); else n_pass++;
      n_total++; if (count !== 7'd1) $display("FAIL single_retire_count got %0d exp 1", count); else n_pass++;
      tick();
      n_total++; if (count !== 7'd0 || empty !== 1'b1) $display("FAIL drained got count %0d empty %0d exp 0/1", count, empty); else n_pass++;
      n_total++; if (retire_v_0 !== 1'b0) $display("FAIL drained_retire got %0d exp 0", retire_v_0); else n_pass++;
   endtask

   task automatic test_fill_and_wrap();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      alloc_req = 1'b1;
      repeat (64) tick();
      n_total++; if (count !== 7'd64) $display("FAIL full_count got %0d exp 64", count); else n_pass++;
      n_total++; if (alloc_ready !== 1'b0 || stall !== 1'b1) $display("FAIL full_ready got %0d stall %0d exp 0/1", alloc_ready, stall); else n_pass++;
      tick();
      n_total++; if (count !== 7'd64 || alloc_idx !== 6'd0) $display("FAIL full_ignore got count %0d tail %0d exp 64/0", count, alloc_idx); else n_pass++;
      alloc_req = 1'b0;
      cmpl_v_0 = 1'b1; cmpl_idx_0 = 6'd0;
      tick();
      clr_cmpl();
      alloc_req = 1'b1;
      n_total++; if (retire_v_0 !== 1'b1 || retire_v_1 !== 1'b0) $display("FAIL full_retire got %0d%0d exp 10", retire_v_0, retire_v_1); else n_pass++;
      n_total++; if (alloc_ready !== 1'b0) $display("FAIL ready_during_retire got %0d exp 0", alloc_ready); else n_pass++;
      tick();
      n_total++; if (alloc_ready !== 1'b1 || count !== 7'd63) $display("FAIL ready_after_retire got %0d count %0d exp 1/63", alloc_ready, count); else n_pass++;
      tick();
      alloc_req = 1'b0;
      n_total++; if (count !== 7'd64 || alloc_idx !== 6'd1) $display("FAIL refill got count %0d tail %0d exp 64/1", count, alloc_idx); else n_pass++;
      for (int i = 1; i <= 62; i++) begin
         cmpl_v_0 = 1'b1; cmpl_idx_0 = 6'(i);
         tick();
      end
      clr_cmpl();
      repeat (4) tick();
      n_total++; if (retire_v_0 !== 1'b0 || retire_idx_0 !== 6'd63 || retire_idx_1 !== 6'd0) $display("FAIL pre_wrap got v%0d idx %0d,%0d exp v0 idx 63,0", retire_v_0, retire_idx_0, retire_idx_1); else n_pass++;
      n_total++; if (count !== 7'd2) $display("FAIL pre_wrap_count got %0d exp 2", count); else n_pass++;
      cmpl_v_1 = 1'b1; cmpl_idx_1 = 6'd63;
      cmpl_v_2 = 1'b1; cmpl_idx_2 = 6'd0;
      tick();
      clr_cmpl();
      n_total++; if (retire_v_0 !== 1'b1 || retire_v_1 !== 1'b1) $display("FAIL wrap_retire_v got %0d%0d exp 11", retire_v_0, retire_v_1); else n_pass++;
      n_total++; if (retire_idx_0 !== 6'd63 || retire_idx_1 !== 6'd0) $display("FAIL wrap_retire_idx got %0d,%0d exp 63,0", retire_idx_0, retire_idx_1); else n_pass++;
      tick();
      n_total++; if (retire_idx_0 !== 6'd1 || count !== 7'd0 || empty !== 1'b1) $display("FAIL post_wrap got head %0d count %0d exp 1/0", retire_idx_0, count); else n_pass++;
   endtask

   task automatic test_flush();
      alloc_req = 1'b1;
      repeat (10) tick();
      alloc_req = 1'b0;
      cmpl_v_0 = 1'b1; cmpl_idx_0 = 6'd1;
      tick();
      n_total++; if (count !== 7'd10 || retire_v_0 !== 1'b1) $display("FAIL pre_flush got count %0d rv %0d exp 10/1", count, retire_v_0); else n_pass++;
      flush = 1'b1; alloc_req = 1'b1;
      cmpl_v_0 = 1'b1; cmpl_idx_0 = 6'd2;
      tick();
      flush = 1'b0; alloc_req = 1'b0;
      clr_cmpl();
      n_total++; if (count !== 7'd0 || empty !== 1'b1) $display("FAIL flush_count got %0d exp 0", count); else n_pass++;
      n_total++; if (alloc_idx !== 6'd0 || retire_idx_0 !== 6'd0) $display("FAIL flush_ptrs got tail %0d head %0d exp 0/0", alloc_idx, retire_idx_0); else n_pass++;
      n_total++; if (retire_v_0 !== 1'b0) $display("FAIL flush_retire got %0d exp 0", retire_v_0); else n_pass++;
   endtask

   task automatic test_invalid_cmpl_and_reset();
      cmpl_v_0 = 1'b1; cmpl_idx_0 = 6'd0;
      cmpl_v_1 = 1'b1; cmpl_idx_1 = 6'd1;
      tick();
      clr_cmpl();
      n_total++; if (retire_v_0 !== 1'b0 || count !== 7'd0) $display("FAIL cmpl_after_flush got rv %0d count %0d exp 0/0", retire_v_0, count); else n_pass++;
      alloc_req = 1'b1;
      repeat (2) tick();
      alloc_req = 1'b0;
      cmpl_v_0 = 1'b1; cmpl_idx_0 = 6'd40;
      tick();
      clr_cmpl();
      n_total++; if (retire_v_0 !== 1'b0 || count !== 7'd2 || alloc_idx !== 6'd2) $display("FAIL invalid_cmpl got rv %0d count %0d tail %0d exp 0/2/2", retire_v_0, count, alloc_idx); else n_pass++;
      cmpl_v_0 = 1'b1; cmpl_idx_0 = 6'd0;
      cmpl_v_1 = 1'b1; cmpl_idx_1 = 6'd0;
      cmpl_v_2 = 1'b1; cmpl_idx_2 = 6'd0;
      tick();
      clr_cmpl();
      n_total++; if (retire_v_0 !== 1'b1 || retire_v_1 !== 1'b0) $display("FAIL dup_cmpl got %0d%0d exp 10", retire_v_0, retire_v_1); else n_pass++;
      tick();
      n_total++; if (count !== 7'd1 || retire_idx_0 !== 6'd1) $display("FAIL dup_retire got count %0d head %0d exp 1/1", count, retire_idx_0); else n_pass++;
      cmpl_v_0 = 1'b1; cmpl_idx_0 = 6'd1;
      tick();
      clr_cmpl();
      n_total++; if (retire_v_0 !== 1'b1) $display("FAIL pre_reset_retire got %0d exp 1", retire_v_0); else n_pass++;
      #2 rstn = 1'b0;
      #1;
      n_total++; if (retire_v_0 !== 1'b0 || retire_v_1 !== 1'b0) $display("FAIL async_rst_retire got %0d%0d exp 00", retire_v_0, retire_v_1); else n_pass++;
      n_total++; if (count !== 7'd0 || empty !== 1'b1 || alloc_ready !== 1'b1) $display("FAIL async_rst_count got %0d exp 0", count); else n_pass++;
      n_total++; if (alloc_idx !== 6'd0 || retire_idx_0 !== 6'd0 || retire_idx_1 !== 6'd1) $display("FAIL async_rst_ptrs got %0d %0d %0d exp 0 0 1", alloc_idx, retire_idx_0, retire_idx_1); else n_pass++;
      tick();
      rstn = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_alloc_basic();
      test_complete_retire();
      test_fill_and_wrap();
      test_flush();
      test_invalid_cmpl_and_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
